// File: rtl/ryuki_datatypes.sv
// Shared trace types for the ryuki trace scheduler: event codes, record layout,
// slot wrapper and the field-stamping helper used by the slot file.
package ryuki_datatypes;

    localparam int unsigned DATA_WIDTH   = 32;
    localparam int unsigned ADDR_WIDTH   = 32;
    localparam int unsigned TRACE_TIME_W = 32;

    typedef logic [TRACE_TIME_W-1:0] trace_time_t;

    typedef enum logic [3:0] {
        EV_IF_END        = 4'd0,
        EV_ID_START      = 4'd1,
        EV_ID_END        = 4'd2,
        EV_EX_START      = 4'd3,
        EV_EX_END        = 4'd4,
        EV_WB_START      = 4'd5,
        EV_WB_END        = 4'd6,
        EV_IF_MREQ_START = 4'd7,
        EV_IF_MREQ_END   = 4'd8,
        EV_IF_MRES_START = 4'd9,
        EV_IF_MRES_END   = 4'd10,
        EV_EX_MREQ_START = 4'd11,
        EV_EX_MREQ_END   = 4'd12,
        EV_WB_MRES_START = 4'd13,
        EV_WB_MRES_END   = 4'd14,
        EV_RETIRE        = 4'd15
    } trace_event_e;

    typedef struct packed {
        trace_time_t time_start;
        trace_time_t time_end;
    } trace_span_t;

    typedef struct packed {
        trace_time_t time_start;
        trace_time_t time_end;
        trace_span_t mem_access_req;
        trace_span_t mem_access_res;
    } trace_if_t;

    typedef struct packed {
        trace_time_t time_start;
        trace_time_t time_end;
    } trace_id_t;

    typedef struct packed {
        trace_time_t time_start;
        trace_time_t time_end;
        trace_span_t mem_access_req;
    } trace_ex_t;

    typedef struct packed {
        trace_time_t time_start;
        trace_time_t time_end;
        trace_span_t mem_access_res;
    } trace_wb_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0] addr;
        logic                  pass_through;
        trace_if_t             if_data;
        trace_id_t             id_data;
        trace_ex_t             ex_data;
        trace_wb_t             wb_data;
    } trace_output;

    typedef struct packed {
        trace_output rec;
        logic        retired;
        logic        valid;
    } trace_slot;

    // Write timestamp t into the field selected by code; RETIRE carries no time.
    function automatic trace_output trace_stamp(trace_output r, trace_event_e code, trace_time_t t);
        trace_output o;
        o = r;
        case (code)
            EV_IF_END:        o.if_data.time_end                  = t;
            EV_ID_START:      o.id_data.time_start                = t;
            EV_ID_END:        o.id_data.time_end                  = t;
            EV_EX_START:      o.ex_data.time_start                = t;
            EV_EX_END:        o.ex_data.time_end                  = t;
            EV_WB_START:      o.wb_data.time_start                = t;
            EV_WB_END:        o.wb_data.time_end                  = t;
            EV_IF_MREQ_START: o.if_data.mem_access_req.time_start = t;
            EV_IF_MREQ_END:   o.if_data.mem_access_req.time_end   = t;
            EV_IF_MRES_START: o.if_data.mem_access_res.time_start = t;
            EV_IF_MRES_END:   o.if_data.mem_access_res.time_end   = t;
            EV_EX_MREQ_START: o.ex_data.mem_access_req.time_start = t;
            EV_EX_MREQ_END:   o.ex_data.mem_access_req.time_end   = t;
            EV_WB_MRES_START: o.wb_data.mem_access_res.time_start = t;
            EV_WB_MRES_END:   o.wb_data.mem_access_res.time_end   = t;
            default:          ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/ryuki_trace_slot_file.sv
// DEPTH-entry trace slot storage: one alloc write port, one event field-write
// port and one head read port. Callers guarantee the ports never collide.
module ryuki_trace_slot_file
    import ryuki_datatypes::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned TAG_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_en,
    input  logic [TAG_W-1:0]      alloc_tag,
    input  logic [DATA_WIDTH-1:0] alloc_instr,
    input  logic [ADDR_WIDTH-1:0] alloc_addr,
    input  logic                  alloc_pass_through,
    input  trace_time_t           alloc_time,
    input  logic                  ev_en,
    input  trace_event_e          ev_code,
    input  logic [TAG_W-1:0]      ev_tag,
    input  trace_time_t           ev_time,
    output logic                  ev_slot_valid,
    output logic                  ev_slot_retired,
    input  logic                  free_en,
    input  logic [TAG_W-1:0]      head_tag,
    output trace_output           head_rec,
    output logic                  head_retired
);

    trace_slot slot_q [DEPTH];
    trace_slot slot_d [DEPTH];

    // Next slot contents: event stamp, then head free, then fresh allocation.
    always_comb begin
        slot_d = slot_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ev_en && ev_tag == TAG_W'(i)) begin
                if (ev_code == EV_RETIRE) begin
                    slot_d[i].retired = 1'b1;
                end else begin
                    slot_d[i].rec = trace_stamp(slot_q[i].rec, ev_code, ev_time);
                end
            end
            if (free_en && head_tag == TAG_W'(i)) begin
                slot_d[i].valid   = 1'b0;
                slot_d[i].retired = 1'b0;
            end
            if (alloc_en && alloc_tag == TAG_W'(i)) begin
                slot_d[i]                         = '0;
                slot_d[i].rec.instr               = alloc_instr;
                slot_d[i].rec.addr                = alloc_addr;
                slot_d[i].rec.pass_through        = alloc_pass_through;
                slot_d[i].rec.if_data.time_start  = alloc_time;
                slot_d[i].valid                   = 1'b1;
            end
        end
    end

    // Slot registers; reset discards every slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            slot_q <= slot_d;
        end
    end

    // Read ports for the event target and the head.
    always_comb begin
        ev_slot_valid   = slot_q[ev_tag].valid;
        ev_slot_retired = slot_q[ev_tag].retired;
        head_rec        = slot_q[head_tag].rec;
        head_retired    = slot_q[head_tag].retired;
    end

endmodule

// File: rtl/ryuki_trace_scheduler.sv
// In-order trace record scheduler: allocates a slot per fetched instruction,
// timestamps stage events against a free-running counter and drains retired
// slots in allocation order through a valid/ready output.
// Optional feature: define RYUKI_TRACE_EVENT_CHECK_EN for a sticky protocol
// error flag; otherwise error_o is tied low and bad events are dropped silently.
module ryuki_trace_scheduler
    import ryuki_datatypes::*;
#(
    parameter  int unsigned DEPTH    = 4,
    parameter  trace_time_t NOW_INIT = '0,
    localparam int unsigned TAG_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid_i,
    input  logic [DATA_WIDTH-1:0] alloc_instr_i,
    input  logic [ADDR_WIDTH-1:0] alloc_addr_i,
    input  logic                  alloc_pass_through_i,
    output logic                  alloc_ready_o,
    output logic [TAG_W-1:0]      alloc_tag_o,
    input  logic                  ev_valid_i,
    input  logic [3:0]            ev_code_i,
    input  logic [TAG_W-1:0]      ev_tag_i,
    output logic                  trace_valid_o,
    output trace_output           trace_o,
    input  logic                  trace_ready_i,
    output logic                  error_o,
    output logic [TAG_W:0]        occupancy_o
);

    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   occ_q, occ_d;
    trace_time_t      now_q, now_d;

    logic        full, empty, alloc_fire, drain, ev_accept;
    logic        ev_slot_valid, ev_slot_retired, head_retired;
    trace_output head_rec;

    // Handshakes, event acceptance and pointer/occupancy next state.
    always_comb begin
        full          = (occ_q == (TAG_W+1)'(DEPTH));
        empty         = (occ_q == '0);
        alloc_ready_o = !full;
        alloc_tag_o   = tail_q;
        alloc_fire    = alloc_valid_i && !full;
        trace_valid_o = !empty && head_retired;
        drain         = trace_valid_o && trace_ready_i;
        trace_o       = trace_valid_o ? head_rec : '0;
        occupancy_o   = occ_q;
        // An event landing on the slot being drained this cycle is discarded.
        ev_accept     = ev_valid_i && ev_slot_valid && !ev_slot_retired
                        && !(drain && ev_tag_i == head_q);
        now_d         = now_q + 1'b1;
        head_d        = drain ? head_q + 1'b1 : head_q;
        tail_d        = alloc_fire ? tail_q + 1'b1 : tail_q;
        occ_d         = occ_q;
        if (alloc_fire && !drain) begin
            occ_d = occ_q + 1'b1;
        end else if (!alloc_fire && drain) begin
            occ_d = occ_q - 1'b1;
        end
    end

    // Pointer, occupancy and cycle counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            now_q  <= NOW_INIT;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            now_q  <= now_d;
        end
    end

`ifdef RYUKI_TRACE_EVENT_CHECK_EN
    logic error_q, error_d;

    // Sticky error on alloc-while-full, event to a free slot, or event after retire.
    always_comb begin
        error_d = error_q
                  | (alloc_valid_i && full)
                  | (ev_valid_i && !ev_slot_valid)
                  | (ev_valid_i && ev_slot_valid && ev_slot_retired);
        error_o = error_q;
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end
`else
    assign error_o = 1'b0;
`endif

    ryuki_trace_slot_file #(
        .DEPTH(DEPTH)
    ) u_slots (
        .clk               (clk),
        .rst               (rst),
        .alloc_en          (alloc_fire),
        .alloc_tag         (tail_q),
        .alloc_instr       (alloc_instr_i),
        .alloc_addr        (alloc_addr_i),
        .alloc_pass_through(alloc_pass_through_i),
        .alloc_time        (now_q),
        .ev_en             (ev_accept),
        .ev_code           (trace_event_e'(ev_code_i)),
        .ev_tag            (ev_tag_i),
        .ev_time           (now_q),
        .ev_slot_valid     (ev_slot_valid),
        .ev_slot_retired   (ev_slot_retired),
        .free_en           (drain),
        .head_tag          (head_q),
        .head_rec          (head_rec),
        .head_retired      (head_retired)
    );

endmodule

// File: tb/tb_ryuki_trace_scheduler.sv
// Directed bench for ryuki_trace_scheduler (DEPTH=4) plus a second instance
// whose counter starts near wrap.
module tb_ryuki_trace_scheduler;
    import ryuki_datatypes::*;

`ifdef RYUKI_TRACE_EVENT_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, alloc_valid, alloc_pt, alloc_ready, ev_valid, trace_valid, trace_ready, error;
    logic [31:0] alloc_instr, alloc_addr;
    logic [1:0]  alloc_tag, ev_tag;
    logic [3:0]  ev_code;
    logic [2:0]  occ;
    trace_output trace;

    logic        w_rst, w_alloc_valid, w_alloc_ready, w_ev_valid, w_trace_valid, w_error;
    logic [1:0]  w_alloc_tag, w_ev_tag;
    logic [3:0]  w_ev_code;
    logic [2:0]  w_occ;
    trace_output w_trace;

    int errors = 0;
    int checks = 0;

    // Reference cycle count matching the scheduler's timestamp base.
    logic [31:0] tb_now;
    always @(posedge clk) tb_now <= rst ? 32'd0 : tb_now + 32'd1;

    ryuki_trace_scheduler #(.DEPTH(4)) u_dut (
        .clk(clk), .rst(rst),
        .alloc_valid_i(alloc_valid), .alloc_instr_i(alloc_instr), .alloc_addr_i(alloc_addr),
        .alloc_pass_through_i(alloc_pt), .alloc_ready_o(alloc_ready), .alloc_tag_o(alloc_tag),
        .ev_valid_i(ev_valid), .ev_code_i(ev_code), .ev_tag_i(ev_tag),
        .trace_valid_o(trace_valid), .trace_o(trace), .trace_ready_i(trace_ready),
        .error_o(error), .occupancy_o(occ)
    );

    ryuki_trace_scheduler #(.DEPTH(4), .NOW_INIT(32'hFFFF_FFFE)) u_wrap (
        .clk(clk), .rst(w_rst),
        .alloc_valid_i(w_alloc_valid), .alloc_instr_i(32'h0000_0077), .alloc_addr_i(32'h0000_0200),
        .alloc_pass_through_i(1'b0), .alloc_ready_o(w_alloc_ready), .alloc_tag_o(w_alloc_tag),
        .ev_valid_i(w_ev_valid), .ev_code_i(w_ev_code), .ev_tag_i(w_ev_tag),
        .trace_valid_o(w_trace_valid), .trace_o(w_trace), .trace_ready_i(1'b0),
        .error_o(w_error), .occupancy_o(w_occ)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_alloc(input logic [31:0] instr, input logic [31:0] addr, input logic pt);
        alloc_valid = 1'b1; alloc_instr = instr; alloc_addr = addr; alloc_pt = pt;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_ev(input logic [3:0] code, input logic [1:0] tag);
        ev_valid = 1'b1; ev_code = code; ev_tag = tag;
        tick();
        ev_valid = 1'b0;
    endtask

    logic [31:0] t_a, t_b, t_c, t_d, t_last, t_c0;

    initial begin
        rst = 1'b1; alloc_valid = 1'b0; alloc_instr = '0; alloc_addr = '0; alloc_pt = 1'b0;
        ev_valid = 1'b0; ev_code = '0; ev_tag = '0; trace_ready = 1'b0;
        w_rst = 1'b1; w_alloc_valid = 1'b0; w_ev_valid = 1'b0; w_ev_code = '0; w_ev_tag = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state (cycle now=0).
        chk("rst_ready", alloc_ready, 1);
        chk("rst_tag", alloc_tag, 0);
        chk("rst_valid", trace_valid, 0);
        chk("rst_trace_zero", trace == '0, 1);
        chk("rst_error", error, 0);
        chk("rst_occ", occ, 0);

        // Single instruction: alloc at now=5, events at 6..13, record at 14.
        repeat (5) tick();
        do_alloc(32'h0000_0013, 32'h0000_0080, 1'b1);
        chk("a1_occ", occ, 1);
        chk("a1_tag", alloc_tag, 1);
        do_ev(4'd0, 2'd0); do_ev(4'd1, 2'd0); do_ev(4'd2, 2'd0); do_ev(4'd3, 2'd0);
        do_ev(4'd4, 2'd0); do_ev(4'd5, 2'd0); do_ev(4'd6, 2'd0);
        chk("a1_not_retired", trace_valid, 0);
        do_ev(4'd15, 2'd0);
        chk("a1_valid", trace_valid, 1);
        chk("a1_instr", trace.instr, 32'h13);
        chk("a1_addr", trace.addr, 32'h80);
        chk("a1_pt", trace.pass_through, 1);
        chk("a1_if_s", trace.if_data.time_start, 5);
        chk("a1_if_e", trace.if_data.time_end, 6);
        chk("a1_id_s", trace.id_data.time_start, 7);
        chk("a1_id_e", trace.id_data.time_end, 8);
        chk("a1_ex_s", trace.ex_data.time_start, 9);
        chk("a1_ex_e", trace.ex_data.time_end, 10);
        chk("a1_wb_s", trace.wb_data.time_start, 11);
        chk("a1_wb_e", trace.wb_data.time_end, 12);
        chk("a1_ifmreq_s", trace.if_data.mem_access_req.time_start, 0);
        chk("a1_wbmres_e", trace.wb_data.mem_access_res.time_end, 0);
        trace_ready = 1'b1; tick(); trace_ready = 1'b0;
        chk("a1_drained", trace_valid, 0);
        chk("a1_occ0", occ, 0);

        // Out-of-order retire, memory events and overwrite.
        do_alloc(32'h0000_00A0, 32'h100, 1'b0);
        chk("b_tag2", alloc_tag, 2);
        do_alloc(32'h0000_00B0, 32'h104, 1'b0);
        t_a = tb_now; do_ev(4'd7, 2'd1);
        t_b = tb_now; do_ev(4'd8, 2'd1);
        t_c = tb_now; do_ev(4'd11, 2'd1);
        t_d = tb_now; do_ev(4'd14, 2'd1);
        do_ev(4'd0, 2'd2);
        t_last = tb_now; do_ev(4'd0, 2'd2);
        do_ev(4'd15, 2'd2);
        chk("b_wait0", trace_valid, 0);
        tick();
        chk("b_wait1", trace_valid, 0);
        do_ev(4'd15, 2'd1);
        chk("b_a_valid", trace_valid, 1);
        chk("b_a_instr", trace.instr, 32'hA0);
        chk("b_a_mreq_s", trace.if_data.mem_access_req.time_start, t_a);
        chk("b_a_mreq_e", trace.if_data.mem_access_req.time_end, t_b);
        chk("b_a_exmreq_s", trace.ex_data.mem_access_req.time_start, t_c);
        chk("b_a_wbmres_e", trace.wb_data.mem_access_res.time_end, t_d);
        chk("b_a_if_e", trace.if_data.time_end, 0);
        trace_ready = 1'b1; tick();
        chk("b_b_valid", trace_valid, 1);
        chk("b_b_instr", trace.instr, 32'hB0);
        chk("b_b_overwrite", trace.if_data.time_end, t_last);
        tick(); trace_ready = 1'b0;
        chk("b_empty", trace_valid, 0);
        chk("b_occ0", occ, 0);

        // Backpressure: record held for three cycles, taken on first ready.
        chk("c_tag3", alloc_tag, 3);
        t_c0 = tb_now;
        do_alloc(32'h0000_00C0, 32'h108, 1'b0);
        do_ev(4'd15, 2'd3);
        for (int i = 0; i < 3; i++) begin
            chk("c_hold_valid", trace_valid, 1);
            chk("c_hold_instr", trace.instr, 32'hC0);
            chk("c_hold_if_s", trace.if_data.time_start, t_c0);
            tick();
        end
        trace_ready = 1'b1; tick(); trace_ready = 1'b0;
        chk("c_taken", trace_valid, 0);
        chk("c_occ0", occ, 0);

        // Fill to DEPTH, overflow alloc, then drain+alloc in the same cycle.
        for (int i = 0; i < 4; i++) begin
            chk("d_tag", alloc_tag, i);
            do_alloc(32'h0000_00E0 + i, 32'h200, 1'b0);
        end
        chk("d_full_ready", alloc_ready, 0);
        chk("d_full_occ", occ, 4);
        do_alloc(32'h0000_00EF, 32'h200, 1'b0);
        chk("d_drop_occ", occ, 4);
        chk("d_drop_tag", alloc_tag, 0);
        chk("d_error", error, EXP_ERR);
        do_ev(4'd15, 2'd0);
        chk("d_head_valid", trace_valid, 1);
        chk("d_head_instr", trace.instr, 32'hE0);
        trace_ready = 1'b1; alloc_valid = 1'b1; alloc_instr = 32'h0000_00E5;
        tick();
        trace_ready = 1'b0;
        chk("d_refused_occ", occ, 3);
        chk("d_ready_again", alloc_ready, 1);
        chk("d_tag_old_head", alloc_tag, 0);
        tick();
        alloc_valid = 1'b0;
        chk("d_accept_occ", occ, 4);
        do_ev(4'd15, 2'd1); do_ev(4'd15, 2'd2); do_ev(4'd15, 2'd3); do_ev(4'd15, 2'd0);
        trace_ready = 1'b1;
        chk("d_out0", trace.instr, 32'hE1); tick();
        chk("d_out1", trace.instr, 32'hE2); tick();
        chk("d_out2", trace.instr, 32'hE3); tick();
        chk("d_out3", trace.instr, 32'hE5); tick();
        trace_ready = 1'b0;
        chk("d_occ0", occ, 0);

        // Reset mid-operation, then event to a free slot.
        do_alloc(32'h0000_00F0, 32'h300, 1'b0);
        do_ev(4'd15, 2'd1);
        chk("e_valid_pre", trace_valid, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("e_rst_valid", trace_valid, 0);
        chk("e_rst_occ", occ, 0);
        chk("e_rst_trace", trace == '0, 1);
        chk("e_rst_error", error, 0);
        chk("e_rst_tag", alloc_tag, 0);
        do_ev(4'd2, 2'd2);
        chk("e_free_ev_error", error, EXP_ERR);
        chk("e_free_ev_occ", occ, 0);

        // Event after retire is ignored.
        rst = 1'b1; tick(); rst = 1'b0;
        do_alloc(32'h0000_0066, 32'h400, 1'b0);
        do_ev(4'd15, 2'd0);
        chk("f_error_clear", error, 0);
        do_ev(4'd0, 2'd0);
        chk("f_late_ev_error", error, EXP_ERR);
        chk("f_valid", trace_valid, 1);
        chk("f_ignored", trace.if_data.time_end, 0);

        // Counter wrap: alloc at 0xFFFFFFFE, IF_END three cycles later at 1.
        tick();
        w_rst = 1'b0;
        w_alloc_valid = 1'b1; tick(); w_alloc_valid = 1'b0;
        tick(); tick();
        w_ev_valid = 1'b1; w_ev_code = 4'd0; w_ev_tag = 2'd0; tick();
        w_ev_code = 4'd15; tick();
        w_ev_valid = 1'b0;
        chk("w_valid", w_trace_valid, 1);
        chk("w_if_s", w_trace.if_data.time_start, 32'hFFFF_FFFE);
        chk("w_if_e", w_trace.if_data.time_end, 32'h0000_0001);
        chk("w_occ", w_occ, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
